pic_ack_sequencer: RTL

Sequences the 8259-style interrupt acknowledge cycle between the masked interrupt request register and the CPU. It resolves the highest-priority pending request against the in-service register (fully nested, IR0 highest), raises INT, and tracks the two-pulse INTA handshake. It also sets/clears the in-service register, tells the request register which bit to clear, and drives the 8-bit vector on the second pulse. It sits between the request register and the data-bus buffer; configuration comes from the command-word logic.

---
 rtl/pic_ack_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pic_ack_sequencer.sv
// ---------------------------------------------------------------------------
// pic_ack_sequencer
//
// Runs the 8259-style interrupt acknowledge handshake between the masked
// request register and the CPU. It picks the highest-priority pending
// request (IR0 highest, fully nested against the in-service register),
// raises INT, follows the two-pulse INTA sequence, maintains the in-service
// register and drives the interrupt vector on the second INTA pulse.
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_irr[7:0]       masked pending requests
//   i_inta_n         CPU acknowledge strobe (active-low, synchronous to clk)
//   i_eoi            one-cycle end-of-interrupt pulse
//   i_eoi_specific   1 = clear isr[i_eoi_level], 0 = clear highest isr bit
//   i_eoi_level[2:0] level used by a specific EOI
//   i_auto_eoi       clear the serviced isr bit at the end of the 2nd INTA
//   i_vector_base    vector bits 7:3
//   o_int_out        interrupt request to the CPU
//   o_isr[7:0]       in-service register
//   o_clear_request  one-hot single-cycle pulse to drop a request bit
//   o_data_out[7:0]  vector {vector_base, level}
//   o_data_oe        o_data_out valid / bus enable
// ---------------------------------------------------------------------------
module pic_ack_sequencer (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_irr,
   input  logic       i_inta_n,
   input  logic       i_eoi,
   input  logic       i_eoi_specific,
   input  logic [2:0] i_eoi_level,
   input  logic       i_auto_eoi,
   input  logic [4:0] i_vector_base,
   output logic       o_int_out,
   output logic [7:0] o_isr,
   output logic [7:0] o_clear_request,
   output logic [7:0] o_data_out,
   output logic       o_data_oe
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACK1,
      ST_GAP,
      ST_ACK2
   } state_t;

   state_t     r_state;
   logic       r_inta_n_q;
   logic [2:0] r_lvl;
   logic       r_spurious;
   logic       r_int_out;
   logic [7:0] r_isr;
   logic [7:0] r_clear_request;
   logic [7:0] r_data_out;
   logic       r_data_oe;

   logic       w_inta_fall;
   logic       w_inta_rise;
   logic [3:0] w_req_lvl;
   logic [3:0] w_isr_lvl;
   logic       w_eligible;
   logic [7:0] w_eoi_clr;
   logic [7:0] w_auto_clr;
   logic [7:0] w_isr_set;

   assign w_inta_fall = r_inta_n_q & ~i_inta_n;
   assign w_inta_rise = ~r_inta_n_q & i_inta_n;

   // Priority resolution: lowest set index wins; 8 means "nothing set",
   // which lets an empty isr compare as lower priority than any request.
   always_comb begin
      w_req_lvl = 4'd8;
      w_isr_lvl = 4'd8;
      for (int i = 7; i >= 0; i--) begin
         if (i_irr[i]) w_req_lvl = 4'(i);
         if (r_isr[i]) w_isr_lvl = 4'(i);
      end
   end

   assign w_eligible = (i_irr != 8'h00) && (w_req_lvl < w_isr_lvl);

   // In-service register update masks. EOI clears are computed against the
   // current isr, then the acknowledge set is OR-ed on top so a set of the
   // same bit in the same cycle survives.
   always_comb begin
      w_eoi_clr  = 8'h00;
      w_auto_clr = 8'h00;
      w_isr_set  = 8'h00;
      if (i_eoi) begin
         if (i_eoi_specific)
            w_eoi_clr = 8'h01 << i_eoi_level;
         else if (w_isr_lvl != 4'd8)
            w_eoi_clr = 8'h01 << w_isr_lvl[2:0];
      end
      if ((r_state == ST_REQ) && w_inta_fall && w_eligible)
         w_isr_set = 8'h01 << w_req_lvl[2:0];
      if ((r_state == ST_ACK2) && w_inta_rise && i_auto_eoi && !r_spurious)
         w_auto_clr = 8'h01 << r_lvl;
   end

   // Handshake FSM with all outputs registered. The request is re-resolved
   // at the first INTA fall; if it has vanished the cycle is spurious and
   // services level 7 without touching isr or the request register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= ST_IDLE;
         r_inta_n_q      <= 1'b1;
         r_lvl           <= 3'd0;
         r_spurious      <= 1'b0;
         r_int_out       <= 1'b0;
         r_isr           <= 8'h00;
         r_clear_request <= 8'h00;
         r_data_out      <= 8'h00;
         r_data_oe       <= 1'b0;
      end else begin
         r_inta_n_q      <= i_inta_n;
         r_clear_request <= 8'h00;
         r_isr           <= (r_isr & ~(w_eoi_clr | w_auto_clr)) | w_isr_set;
         unique case (r_state)
            ST_IDLE: begin
               if (w_eligible) begin
                  r_int_out <= 1'b1;
                  r_state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (w_inta_fall) begin
                  r_int_out <= 1'b0;
                  if (w_eligible) begin
                     r_lvl           <= w_req_lvl[2:0];
                     r_spurious      <= 1'b0;
                     r_clear_request <= w_isr_set;
                  end else begin
                     r_lvl      <= 3'd7;
                     r_spurious <= 1'b1;
                  end
                  r_state <= ST_ACK1;
               end
            end
            ST_ACK1: begin
               if (w_inta_rise) r_state <= ST_GAP;
            end
            ST_GAP: begin
               if (w_inta_fall) begin
                  r_data_out <= {i_vector_base, r_lvl};
                  r_data_oe  <= 1'b1;
                  r_state    <= ST_ACK2;
               end
            end
            ST_ACK2: begin
               if (w_inta_rise) begin
                  r_data_oe <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_int_out       = r_int_out;
   assign o_isr           = r_isr;
   assign o_clear_request = r_clear_request;
   assign o_data_out      = r_data_out;
   assign o_data_oe       = r_data_oe;

endmodule
